// File: rtl/fp_sqrt_sequencer.sv
// State register and next-state logic for the FP square-root controller.
// Emits the state code consumed by the output decoder, plus iteration/phase
// decodes and the busy/done handshake flags.
module fp_sqrt_sequencer #(
    parameter int unsigned ITER = 12,
    parameter int unsigned ST_W = 6
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start_i,
    input  logic            sp_case_i,
    input  logic            stall_i,
    input  logic            abort_i,
    output logic [ST_W-1:0] CurrentState,
    output logic [3:0]      iter_o,
    output logic [1:0]      phase_o,
    output logic            busy_o,
    output logic            done_o
);

    // Named codes; iteration steps between S_IT_FIRST and S_LAST are
    // consecutive unnamed codes reached by incrementing.
    typedef enum logic [ST_W-1:0] {
        S_IDLE     = ST_W'(0),
        S_LOAD     = ST_W'(1),
        S_INIT     = ST_W'(2),
        S_IT_FIRST = ST_W'(3),
        S_LAST     = ST_W'(4 * ITER + 1),
        S_OUT      = ST_W'(4 * ITER + 2)
    } state_t;

    state_t          state_q;
    state_t          state_d;
    logic [ST_W-1:0] it_off;
    logic            in_iter;

    // State register with asynchronous active-low reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: abort beats stall beats the normal transition
    always_comb begin
        state_d = state_q;
        if (abort_i) begin
            state_d = S_IDLE;
        end else if (!stall_i) begin
            if (state_q == S_IDLE) begin
                state_d = start_i ? S_LOAD : S_IDLE;
            end else if (state_q == S_LOAD) begin
                state_d = S_INIT;
            end else if (state_q == S_INIT) begin
                state_d = sp_case_i ? S_OUT : S_IT_FIRST;
            end else if (state_q < S_LAST) begin
                state_d = state_t'(state_q + 1'b1);
            end else if (state_q == S_LAST) begin
                state_d = S_OUT;
            end else begin
                // OUT, and any unreachable code above it, returns to IDLE
                state_d = S_IDLE;
            end
        end
    end

    // Output decodes taken directly from the state register
    always_comb begin
        it_off       = state_q - S_IT_FIRST;
        in_iter      = (state_q >= S_IT_FIRST) && (state_q <= S_LAST);
        iter_o       = '0;
        phase_o      = '0;
        if (in_iter) begin
            iter_o  = 4'(it_off >> 2) + 4'd1;
            phase_o = it_off[1:0];
        end
        CurrentState = state_q;
        busy_o       = (state_q != S_IDLE);
        done_o       = (state_q == S_OUT);
    end

endmodule

// File: tb/tb_fp_sqrt_sequencer.sv
// Directed self-checking bench for fp_sqrt_sequencer with ITER=12.
module tb_fp_sqrt_sequencer;

    logic       clk;
    logic       rst_n;
    logic       start_i;
    logic       sp_case_i;
    logic       stall_i;
    logic       abort_i;
    logic [5:0] CurrentState;
    logic [3:0] iter_o;
    logic [1:0] phase_o;
    logic       busy_o;
    logic       done_o;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    fp_sqrt_sequencer #(.ITER(12), .ST_W(6)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start_i      (start_i),
        .sp_case_i    (sp_case_i),
        .stall_i      (stall_i),
        .abort_i      (abort_i),
        .CurrentState (CurrentState),
        .iter_o       (iter_o),
        .phase_o      (phase_o),
        .busy_o       (busy_o),
        .done_o       (done_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Walk states first..last on consecutive edges, checking every decode
    task automatic walk(input int first, input int last, input string tag);
        int ei;
        int ep;
        for (int s = first; s <= last; s++) begin
            @(negedge clk);
            cyc++;
            ei = (s >= 3 && s <= 49) ? (s - 3) / 4 + 1 : 0;
            ep = (s >= 3 && s <= 49) ? (s - 3) % 4 : 0;
            total++;
            if (CurrentState !== 6'(s)) begin
                bad++;
                $display("FAIL %s state: got %0d expected %0d", tag, CurrentState, s);
            end
            total++;
            if (iter_o !== 4'(ei) || phase_o !== 2'(ep)) begin
                bad++;
                $display("FAIL %s iter/phase at %0d: got %0d/%0d expected %0d/%0d",
                         tag, s, iter_o, phase_o, ei, ep);
            end
            total++;
            if (done_o !== (s == 50) || busy_o !== (s != 0)) begin
                bad++;
                $display("FAIL %s done/busy at %0d: got %b/%b", tag, s, done_o, busy_o);
            end
        end
    endtask

    // Pulse start for one edge, leaving the DUT in LOAD at the next sample
    task automatic pulse_start();
        start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        cyc = 1;
        total++;
        if (CurrentState !== 6'd1) begin
            bad++;
            $display("FAIL start->LOAD: got %0d expected 1", CurrentState);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #3;
        total++;
        if (CurrentState !== 6'd0 || busy_o !== 1'b0 || done_o !== 1'b0 ||
            iter_o !== 4'd0 || phase_o !== 2'd0) begin
            bad++;
            $display("FAIL reset: state=%0d busy=%b done=%b iter=%0d phase=%0d expected all 0",
                     CurrentState, busy_o, done_o, iter_o, phase_o);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        total++;
        if (CurrentState !== 6'd0) begin
            bad++;
            $display("FAIL idle_hold: got %0d expected 0", CurrentState);
        end
    endtask

    task automatic test_normal();
        pulse_start();
        walk(2, 50, "normal");
        walk(0, 0, "normal_end");
        total++;
        if (cyc !== 51) begin
            bad++;
            $display("FAIL normal latency: got %0d edges expected 51", cyc);
        end
    endtask

    task automatic test_special();
        pulse_start();
        sp_case_i = 1'b1;
        walk(2, 2, "sp_init");
        walk(50, 50, "sp_out");
        sp_case_i = 1'b0;
        walk(0, 0, "sp_idle");
    endtask

    task automatic test_stall();
        // stall in IDLE swallows a start
        stall_i = 1'b1;
        start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        stall_i = 1'b0;
        @(negedge clk);
        total++;
        if (CurrentState !== 6'd0) begin
            bad++;
            $display("FAIL stall_idle: got %0d expected 0", CurrentState);
        end
        pulse_start();
        walk(2, 20, "pre_stall");
        stall_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            cyc++;
            total++;
            if (CurrentState !== 6'd20 || iter_o !== 4'd5 || phase_o !== 2'd1) begin
                bad++;
                $display("FAIL stall_hold: got %0d iter %0d phase %0d expected 20/5/1",
                         CurrentState, iter_o, phase_o);
            end
        end
        stall_i = 1'b0;
        walk(21, 50, "post_stall");
        total++;
        if (cyc !== 53) begin
            bad++;
            $display("FAIL stall latency: done after %0d edges expected 53", cyc);
        end
        // stall in OUT keeps done high
        stall_i = 1'b1;
        @(negedge clk);
        total++;
        if (CurrentState !== 6'd50 || done_o !== 1'b1) begin
            bad++;
            $display("FAIL stall_out: got %0d done %b expected 50/1", CurrentState, done_o);
        end
        stall_i = 1'b0;
        walk(0, 0, "stall_end");
    endtask

    task automatic test_abort();
        pulse_start();
        walk(2, 30, "pre_abort");
        abort_i = 1'b1;
        stall_i = 1'b1;
        @(negedge clk);
        stall_i = 1'b0;
        total++;
        if (CurrentState !== 6'd0 || done_o !== 1'b0) begin
            bad++;
            $display("FAIL abort: got %0d done %b expected 0/0", CurrentState, done_o);
        end
        // abort beats start in IDLE
        start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        abort_i = 1'b0;
        total++;
        if (CurrentState !== 6'd0) begin
            bad++;
            $display("FAIL abort_vs_start: got %0d expected 0", CurrentState);
        end
        pulse_start();
        walk(2, 50, "after_abort");
        walk(0, 0, "after_abort_end");
    endtask

    task automatic test_async_reset();
        pulse_start();
        walk(2, 17, "pre_reset");
        #2;
        rst_n = 1'b0;
        #1;
        total++;
        if (CurrentState !== 6'd0 || busy_o !== 1'b0 || iter_o !== 4'd0) begin
            bad++;
            $display("FAIL async_reset: got %0d busy %b iter %0d expected 0/0/0",
                     CurrentState, busy_o, iter_o);
        end
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        total++;
        if (CurrentState !== 6'd0 || done_o !== 1'b0) begin
            bad++;
            $display("FAIL post_reset: got %0d done %b expected 0/0", CurrentState, done_o);
        end
    endtask

    task automatic test_back_to_back();
        start_i = 1'b1;
        for (int op = 0; op < 2; op++) begin
            walk(1, 50, "b2b");
            walk(0, 0, "b2b_idle");
        end
        start_i = 1'b0;
        walk(0, 0, "b2b_stop");
    endtask

    initial begin
        start_i   = 1'b0;
        sp_case_i = 1'b0;
        stall_i   = 1'b0;
        abort_i   = 1'b0;
        rst_n     = 1'b1;
        test_reset();
        test_normal();
        test_special();
        test_stall();
        test_abort();
        test_async_reset();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
